mspe_src_arbiter: RTL and testbench
===================================

# mspe_src_arbiter

Packet-level round-robin arbiter that drains the per-core source FIFOs of the MSPE cluster onto the single 512-bit output stream. Each core's source FIFO (first-word-fall-through) presents its head beat and occupancy; the arbiter admits a packet only once it is completely resident, then streams it with `src_sop`/`src_eop` under a valid/ready handshake. It sits between the per-core `src_fifo` instances and the cluster `src_*` port, replacing ad-hoc output sequencing.

## Interface
- `CORES`, 4: number of requesters (1..32).
- `LEN_W`, 16: width of the packet-length field in the header beat.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_enable`  in  CORES  per-core eligibility mask (driven from `core_run`); 0 excludes the core from new grants.
- `req_count`  in  CORES*32  packed FIFO read counts, core i at `[32*i+:32]`.
- `req_data`  in  CORES*512  packed FIFO head beats, core i at `[512*i+:512]`; valid when its count is nonzero.
- `req_re`  out  CORES  one-hot pop strobe; head advances next cycle, count decrements next cycle.
- `src_data`  out  512  output beat.
- `src_valid`  out  1  output beat valid.
- `src_sop`  out  1  first beat of packet.
- `src_eop`  out  1  last beat of packet.
- `src_ready`  in  1  downstream accepts beat when `src_valid & src_ready`.
- `grant_id`  out  5  index of core currently/last granted.
- `pkt_done`  out  1  one-cycle pulse when the eop beat is accepted.
- `len_err`  out  1  one-cycle pulse when a zero length header is granted.

## Operation
- Header: first beat of every packet carries length L = `data[LEN_W-1:0]`, in beats, header included. L=0 is treated as L=1 and pulses `len_err`.
- Core i is eligible when `req_enable[i]`, `req_count[i] != 0`, and `req_count[i] >= max(L_i,1)`.
- States: IDLE, STREAM.
- IDLE: search eligible cores starting at `rr_ptr`, ascending with wrap; first hit wins. On win: latch `grant_id`, `beats_left <= max(L,1)`, go STREAM. No eligible core: stay.
- STREAM: pop when `beats_left != 0` and output register free (`!src_valid | src_ready`). Pop loads `src_data <= head`, `src_valid <= 1`, `src_sop <= (first pop)`, `src_eop <= (beats_left == 1)`, `beats_left--`. After final pop: `rr_ptr <= grant_id+1` (wrap to 0 at CORES), go IDLE.
- Output register holding an accepted beat with no new pop: `src_valid <= 0`.
- `req_enable` deassert mid-packet does not abort; packet completes.
- `pkt_done` = `src_valid & src_ready & src_eop`.
- `req_re` is never asserted for a core other than `grant_id`, never in IDLE, never when its count is zero.

## Timing
- Reset (async assert, sync release): state IDLE, `rr_ptr`=0, `beats_left`=0, `grant_id`=0, `req_re`=0, `src_valid`/`src_sop`/`src_eop`=0, `src_data`=0, `pkt_done`=0, `len_err`=0. Reset mid-packet discards the packet; FIFO residue is not restored.
- Arbitration: 1 cycle (IDLE); first pop the cycle after grant; `src_valid` rises the cycle after first pop. Latency eligible→`src_valid` = 3 cycles.
- Throughput: one beat per cycle with `src_ready` held high; 1 idle cycle between packets (IDLE), may overlap draining of eop beat.
- Backpressure: `src_data`/`src_sop`/`src_eop` held stable while `src_valid & !src_ready`; no pop occurs.
- Single-beat packet: `src_sop` and `src_eop` both 1.

## Configuration
- `MSPE_ARB_FIXED_PRIO_EN` defined: search always starts at core 0 (lowest index wins); `rr_ptr` unused and held 0.
- Not defined: round-robin as above.

## Test plan
- Reset: hold `reset_n`=0 with all cores eligible -> all outputs 0, no `req_re`; release -> grant on cycle 1, `src_valid` on cycle 3.
- Single core, L=4, `src_ready`=1 -> 4 consecutive beats, sop on beat 0, eop on beat 3, exactly 4 `req_re` pulses, one `pkt_done`.
- Cores 0,1,2 each with L=2 resident -> grant order 0,1,2, then back to 0; with `MSPE_ARB_FIXED_PRIO_EN` and core 0 refilled each time -> core 0 repeatedly, core 1 starved.
- Partial packet: core 1 count=2, L=5 -> no grant; count reaches 5 -> grant, 5 beats.
- Backpressure: L=3, `src_ready` toggles 1,0,0,1,1 -> data stable during stalls, no extra pops, beats in order.
- Header L=0 -> `len_err` pulse, one beat with sop=eop=1.

Source files
------------

// File: rtl/mspe_src_arbiter.sv
// ---------------------------------------------------------------------------
// mspe_src_arbiter
//
// Packet-level round-robin arbiter draining the per-core first-word-fall-
// through source FIFOs onto the single 512-bit cluster output stream. A core
// is granted only when its whole packet is resident in its FIFO (occupancy
// >= header length). The packet is then streamed through a one-beat output
// register under a valid/ready handshake.
//
// Ports
//   clk, reset_n  : clock, asynchronous active-low reset
//   req_enable    : per-core eligibility mask for new grants
//   req_count     : packed FIFO occupancies, core i at [32*i +: 32]
//   req_data      : packed FIFO head beats, core i at [512*i +: 512]
//   req_re        : one-hot FIFO pop strobe (only the granted core)
//   src_data/src_valid/src_sop/src_eop/src_ready : output stream
//   grant_id      : index of the core currently / last granted
//   pkt_done      : eop beat accepted downstream
//   len_err       : one-cycle pulse after a zero-length header is granted
//
// Build option
//   MSPE_ARB_FIXED_PRIO_EN : when defined the search always starts at core 0
//                            (lowest index wins) and the round-robin pointer
//                            is held at 0. Undefined: round-robin.
// ---------------------------------------------------------------------------
module mspe_src_arbiter #(
    parameter int CORES = 4,
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CORES-1:0]     req_enable,
    input  logic [CORES*32-1:0]  req_count,
    input  logic [CORES*512-1:0] req_data,
    output logic [CORES-1:0]     req_re,
    output logic [511:0]         src_data,
    output logic                 src_valid,
    output logic                 src_sop,
    output logic                 src_eop,
    input  logic                 src_ready,
    output logic [4:0]           grant_id,
    output logic                 pkt_done,
    output logic                 len_err
);

    localparam int IW = (CORES > 1) ? $clog2(CORES) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_grant;
    logic [LEN_W-1:0]  r_beats_left;
    logic              r_first;
    logic [511:0]      r_src_data;
    logic              r_src_valid;
    logic              r_src_sop;
    logic              r_src_eop;
    logic              r_len_err;

    logic [31:0]       w_cnt      [CORES];
    logic [511:0]      w_head     [CORES];
    logic [LEN_W-1:0]  w_need     [CORES];
    logic [CORES-1:0]  w_len_zero;
    logic [CORES-1:0]  w_elig;
    logic              w_found;
    logic [IW-1:0]     w_win;
    logic              w_pop;
    logic              w_last_pop;
    logic [IW-1:0]     w_next_ptr;

    // Unpack the per-core lanes. A zero length header still carries one beat.
    for (genvar g = 0; g < CORES; g++) begin : g_lane
        assign w_cnt[g]      = req_count[32*g +: 32];
        assign w_head[g]     = req_data[512*g +: 512];
        assign w_len_zero[g] = (req_data[512*g +: LEN_W] == '0);
        assign w_need[g]     = w_len_zero[g] ? LEN_W'(1) : req_data[512*g +: LEN_W];
        assign w_elig[g]     = req_enable[g] && (w_cnt[g] != 32'd0) &&
                               (w_cnt[g] >= 32'(w_need[g]));
    end

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= CORES) s = s - CORES;
        return IW'(s);
    endfunction

    // Search from the pointer upward with wrap; the first eligible core wins.
    // In fixed-priority builds the pointer is pinned to 0.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        w_found = 1'b0;
        w_win   = '0;
        for (int j = 0; j < CORES; j++) begin
            if (!w_found && w_elig[wrap_add(r_rr_ptr, j)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_rr_ptr, j);
            end
        end
    end

    // A pop needs a beat still owed and a free (or draining) output register.
    assign w_pop      = (r_state == ST_STREAM) && (r_beats_left != '0) &&
                        (!r_src_valid || src_ready) && (w_cnt[r_grant] != 32'd0);
    assign w_last_pop = w_pop && (r_beats_left == LEN_W'(1));
    assign w_next_ptr = (r_grant == IW'(CORES - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_re      = '0;
        case (r_state)
            ST_IDLE:   if (w_found) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_last_pop) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_pop) req_re[r_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_beats_left <= '0;
            r_first      <= 1'b0;
            r_src_data   <= '0;
            r_src_valid  <= 1'b0;
            r_src_sop    <= 1'b0;
            r_src_eop    <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_len_err <= 1'b0;

            if (r_state == ST_IDLE && w_found) begin
                r_grant      <= w_win;
                r_beats_left <= w_need[w_win];
                r_first      <= 1'b1;
                r_len_err    <= w_len_zero[w_win];
            end

            if (w_pop) begin
                r_beats_left <= r_beats_left - 1'b1;
                r_first      <= 1'b0;
            end

            if (w_last_pop) begin
`ifdef MSPE_ARB_FIXED_PRIO_EN
                r_rr_ptr <= '0;
`else
                r_rr_ptr <= w_next_ptr;
`endif
            end

            // Output register: load on pop, otherwise drop valid once the
            // held beat has been accepted. Stalled beats are left untouched.
            if (w_pop) begin
                r_src_data  <= w_head[r_grant];
                r_src_valid <= 1'b1;
                r_src_sop   <= r_first;
                r_src_eop   <= (r_beats_left == LEN_W'(1));
            end else if (r_src_valid && src_ready) begin
                r_src_valid <= 1'b0;
            end
        end
    end

    assign src_data  = r_src_data;
    assign src_valid = r_src_valid;
    assign src_sop   = r_src_sop;
    assign src_eop   = r_src_eop;
    assign grant_id  = 5'(r_grant);
    assign len_err   = r_len_err;
    assign pkt_done  = r_src_valid & src_ready & r_src_eop;

endmodule

// File: tb/tb_mspe_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mspe_src_arbiter
//
// Bench for mspe_src_arbiter. Each core's source FIFO is modelled as a queue
// that is popped on req_re. When a packet is loaded the beats it must produce
// on the output stream are pushed to a scoreboard in the expected grant
// order; accepted output beats are popped from the scoreboard and compared.
// ---------------------------------------------------------------------------
module tb_mspe_src_arbiter;

    localparam int CORES = 4;
    localparam int LEN_W = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [CORES-1:0]     req_enable;
    logic [CORES*32-1:0]  req_count;
    logic [CORES*512-1:0] req_data;
    logic [CORES-1:0]     req_re;
    logic [511:0]         src_data;
    logic                 src_valid;
    logic                 src_sop;
    logic                 src_eop;
    logic                 src_ready;
    logic [4:0]           grant_id;
    logic                 pkt_done;
    logic                 len_err;

    always #5 clk = ~clk;

    mspe_src_arbiter #(.CORES(CORES), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_enable (req_enable),
        .req_count  (req_count),
        .req_data   (req_data),
        .req_re     (req_re),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_sop    (src_sop),
        .src_eop    (src_eop),
        .src_ready  (src_ready),
        .grant_id   (grant_id),
        .pkt_done   (pkt_done),
        .len_err    (len_err)
    );

    typedef struct {
        logic [511:0] data;
        logic         sop;
        logic         eop;
    } exp_t;

    exp_t         sb [$];
    logic [511:0] fq [CORES][$];

    int checks     = 0;
    int errors     = 0;
    int pop_cnt    = 0;
    int done_cnt   = 0;
    int lenerr_cnt = 0;
    int cyc        = 0;
    int first_acc  = 0;
    int last_acc   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_beat(input int core, input int pkt, input int beat, input int len);
        logic [511:0] b;
        b          = '0;
        b[511:504] = 8'(core);
        b[503:488] = 16'(pkt);
        b[487:472] = 16'(beat);
        b[300:269] = 32'(core * 7919 + pkt * 104729 + beat * 13) ^ 32'hA5A5_5A5A;
        b[15:0]    = (beat == 0) ? 16'(len) : 16'hFFFF;
        return b;
    endfunction

    task automatic refresh();
        for (int i = 0; i < CORES; i++) begin
            req_count[32*i +: 32]   = 32'(fq[i].size());
            req_data[512*i +: 512]  = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic load(input int core, input int pkt, input int len, input int lo, input int hi);
        for (int b = lo; b <= hi; b++) fq[core].push_back(mk_beat(core, pkt, b, len));
        refresh();
    endtask

    task automatic expect_pkt(input int core, input int pkt, input int len);
        int   nb;
        exp_t e;
        nb = (len == 0) ? 1 : len;
        for (int b = 0; b < nb; b++) begin
            e.data = mk_beat(core, pkt, b, len);
            e.sop  = (b == 0);
            e.eop  = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < CORES; i++) fq[i].delete();
        sb.delete();
        refresh();
        src_ready  = 1'b1;
        req_enable = '1;
        repeat (2) @(posedge clk);
        #2;
        reset_n    = 1'b1;
        pop_cnt    = 0;
        done_cnt   = 0;
        lenerr_cnt = 0;
    endtask

    task automatic drain(input int max_cyc);
        int c;
        c = 0;
        while (sb.size() != 0 && c < max_cyc) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #2;
        check("drain_empty", sb.size(), 0);
    endtask

    // FIFO model: pop on the strobe seen at the edge, present the new head
    // shortly after the edge.
    always @(posedge clk) begin
        logic [CORES-1:0] v_re;
        cyc++;
        v_re = req_re;
        if (v_re != '0) begin
            check("re_onehot", $onehot(v_re), 1'b1);
            for (int i = 0; i < CORES; i++) begin
                if (v_re[i]) begin
                    check("re_nonempty", fq[i].size() != 0, 1'b1);
                    if (fq[i].size() != 0) void'(fq[i].pop_front());
                    pop_cnt++;
                end
            end
        end
        #1;
        refresh();
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (len_err) lenerr_cnt++;
            if (pkt_done) done_cnt++;
            if (src_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else if (!src_ready) begin
                    check("stall_data", src_data, sb[0].data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", src_data, e.data);
                    check("beat_sop", src_sop, e.sop);
                    check("beat_eop", src_eop, e.eop);
                    check("pkt_done", pkt_done, e.eop);
                    if (e.sop) first_acc = cyc;
                    if (e.eop) last_acc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int pat [5];
        int c;
        pat = '{1, 0, 0, 1, 1};

        // Reset with every core holding a single-beat packet.
        reset_n    = 1'b0;
        src_ready  = 1'b1;
        req_enable = '1;
        req_count  = '0;
        req_data   = '0;
        for (int k = 0; k < CORES; k++) load(k, 0, 1, 0, 0);
        for (int k = 0; k < CORES; k++) expect_pkt(k, 0, 1);
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", src_valid, 1'b0);
        check("rst_sop", src_sop, 1'b0);
        check("rst_eop", src_eop, 1'b0);
        check("rst_data", src_data, '0);
        check("rst_re", req_re, '0);
        check("rst_grant", grant_id, 5'd0);
        check("rst_done", pkt_done, 1'b0);
        check("rst_lenerr", len_err, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        check("c1_grant", grant_id, 5'd0);
        check("c2_pop", req_re, 4'b0001);
        check("c2_novalid", src_valid, 1'b0);
        @(posedge clk);
        #2;
        check("c3_valid", src_valid, 1'b1);
        drain(50);
        check("t1_pops", pop_cnt, 4);
        check("t1_done", done_cnt, 4);

        // Single core, L=4, back to back.
        do_reset();
        load(0, 1, 4, 0, 3);
        expect_pkt(0, 1, 4);
        drain(50);
        check("t2_pops", pop_cnt, 4);
        check("t2_done", done_cnt, 1);
        check("t2_b2b", last_acc - first_acc, 3);

        // Cores 0,1,2 with L=2 resident, core 0 holds a second packet.
        do_reset();
        load(0, 2, 2, 0, 1);
        load(0, 3, 2, 0, 1);
        load(1, 2, 2, 0, 1);
        load(2, 2, 2, 0, 1);
`ifdef MSPE_ARB_FIXED_PRIO_EN
        expect_pkt(0, 2, 2);
        expect_pkt(0, 3, 2);
        expect_pkt(1, 2, 2);
        expect_pkt(2, 2, 2);
`else
        expect_pkt(0, 2, 2);
        expect_pkt(1, 2, 2);
        expect_pkt(2, 2, 2);
        expect_pkt(0, 3, 2);
`endif
        drain(100);
        check("t3_pops", pop_cnt, 8);
        check("t3_done", done_cnt, 4);

        // Partial packet: no grant until fully resident.
        do_reset();
        load(1, 4, 5, 0, 1);
        expect_pkt(1, 4, 5);
        repeat (10) @(posedge clk);
        #2;
        check("t4_no_pop", pop_cnt, 0);
        check("t4_no_valid", src_valid, 1'b0);
        load(1, 4, 5, 2, 4);
        drain(50);
        check("t4_pops", pop_cnt, 5);
        check("t4_done", done_cnt, 1);

        // Backpressure: L=3 with ready pattern 1,0,0,1,1.
        do_reset();
        src_ready = 1'b0;
        load(3, 5, 3, 0, 2);
        expect_pkt(3, 5, 3);
        c = 0;
        while (!src_valid && c < 20) begin
            @(posedge clk);
            #2;
            c++;
        end
        check("t5_valid_seen", src_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            src_ready = (pat[k] != 0);
            @(posedge clk);
            #2;
            if (k == 2) check("t5_stall_nopop", pop_cnt, 2);
        end
        src_ready = 1'b1;
        drain(50);
        check("t5_pops", pop_cnt, 3);
        check("t5_done", done_cnt, 1);

        // Zero-length header followed by a normal single-beat packet.
        do_reset();
        load(2, 6, 0, 0, 0);
        load(2, 7, 1, 0, 0);
        expect_pkt(2, 6, 0);
        expect_pkt(2, 7, 1);
        drain(50);
        check("t6_lenerr", lenerr_cnt, 1);
        check("t6_pops", pop_cnt, 2);
        check("t6_done", done_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
